// File: rtl/div_exec_unit.sv
// rtl/div_exec_unit.sv - multi-cycle integer divide/remainder unit, restoring radix-2, CDB publish
// One instruction in flight; special cases (divide by zero, signed overflow) bypass the iteration.
module div_exec_unit #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             issue_valid,
  input  logic [1:0]       issue_op,
  input  logic [XLEN-1:0]  issue_rs1_data,
  input  logic [XLEN-1:0]  issue_rs2_data,
  input  logic [TAG_W-1:0] issue_rd_tag,
  output logic             ex_done,
  output logic             busy,
  output logic             cdb_req,
  input  logic             cdb_grant,
  output logic [TAG_W-1:0] cdb_tag,
  output logic [XLEN-1:0]  cdb_data
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0]   LAST_STEP = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] INT_MIN   = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONES  = {XLEN{1'b1}};

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_FIX, S_DONE} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CW-1:0]     r_count;
  logic              r_is_rem;
  logic [TAG_W-1:0]  r_tag;
  logic [XLEN-1:0]   r_rem;
  logic [XLEN-1:0]   r_quo;
  logic [XLEN-1:0]   r_divisor;
  logic              r_q_neg;
  logic              r_r_neg;
  logic [TAG_W-1:0]  r_cdb_tag;
  logic [XLEN-1:0]   r_cdb_data;

  logic              w_accept;
  logic              w_signed;
  logic              w_a_neg;
  logic              w_b_neg;
  logic              w_div0;
  logic              w_ovf;
  logic              w_special;
  logic [XLEN-1:0]   w_special_res;
  logic [XLEN-1:0]   w_a_mag;
  logic [XLEN-1:0]   w_b_mag;
  logic [XLEN:0]     w_shift;
  logic [XLEN:0]     w_trial;
  logic [XLEN-1:0]   w_q_fix;
  logic [XLEN-1:0]   w_r_fix;

  // op[0] = unsigned variant, op[1] = remainder variant
  assign w_signed  = ~issue_op[0];
  assign w_a_neg   = w_signed & issue_rs1_data[XLEN-1];
  assign w_b_neg   = w_signed & issue_rs2_data[XLEN-1];
  assign w_a_mag   = w_a_neg ? (~issue_rs1_data + 1'b1) : issue_rs1_data;
  assign w_b_mag   = w_b_neg ? (~issue_rs2_data + 1'b1) : issue_rs2_data;
  assign w_div0    = (issue_rs2_data == '0);
  assign w_ovf     = w_signed && (issue_rs1_data == INT_MIN) && (issue_rs2_data == ALL_ONES);
  assign w_special = w_div0 | w_ovf;

  always_comb begin
    w_special_res = '0;
    if (w_div0) w_special_res = issue_op[1] ? issue_rs1_data : ALL_ONES;
    else        w_special_res = issue_op[1] ? '0 : INT_MIN;
  end

  assign w_shift = {r_rem, r_quo[XLEN-1]};
  assign w_trial = w_shift - {1'b0, r_divisor};
  assign w_q_fix = r_q_neg ? (~r_quo + 1'b1) : r_quo;
  assign w_r_fix = r_r_neg ? (~r_rem + 1'b1) : r_rem;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_accept    = issue_valid && ((r_state == S_IDLE) || ((r_state == S_DONE) && cdb_grant));
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = w_special ? S_DONE : S_BUSY;
      S_BUSY:  if (r_count == LAST_STEP) w_state_nxt = S_FIX;
      S_FIX:   w_state_nxt = S_DONE;
      S_DONE: begin
        if (cdb_grant) begin
          if (w_accept) w_state_nxt = w_special ? S_DONE : S_BUSY;
          else          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    ex_done = w_accept;
    busy    = (r_state != S_IDLE);
    cdb_req = (r_state == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count    <= '0;
      r_is_rem   <= 1'b0;
      r_tag      <= '0;
      r_rem      <= '0;
      r_quo      <= '0;
      r_divisor  <= '0;
      r_q_neg    <= 1'b0;
      r_r_neg    <= 1'b0;
      r_cdb_tag  <= '0;
      r_cdb_data <= '0;
    end else if (w_accept) begin
      r_is_rem <= issue_op[1];
      r_tag    <= issue_rd_tag;
      if (w_special) begin
        r_cdb_tag  <= issue_rd_tag;
        r_cdb_data <= w_special_res;
      end else begin
        r_count   <= '0;
        r_rem     <= '0;
        r_quo     <= w_a_mag;
        r_divisor <= w_b_mag;
        r_q_neg   <= w_a_neg ^ w_b_neg;
        r_r_neg   <= w_a_neg;
      end
    end else begin
      case (r_state)
        S_BUSY: begin
          r_count <= r_count + 1'b1;
          // A clear borrow bit means the divisor fit: keep the difference, shift in a 1
          if (!w_trial[XLEN]) begin
            r_rem <= w_trial[XLEN-1:0];
            r_quo <= {r_quo[XLEN-2:0], 1'b1};
          end else begin
            r_rem <= w_shift[XLEN-1:0];
            r_quo <= {r_quo[XLEN-2:0], 1'b0};
          end
        end
        S_FIX: begin
          r_cdb_tag  <= r_tag;
          r_cdb_data <= r_is_rem ? w_r_fix : w_q_fix;
        end
        default: ;
      endcase
    end
  end

  assign cdb_tag  = r_cdb_tag;
  assign cdb_data = r_cdb_data;

endmodule

// File: tb/tb_div_exec_unit.sv
// tb/tb_div_exec_unit.sv - directed table-driven bench for div_exec_unit
// Vector table plus hand sequences for backpressure, mid-op reset and back-to-back issue.
module tb_div_exec_unit;

  localparam int XLEN  = 32;
  localparam int TAG_W = 6;
  localparam int LAT_NORMAL  = 33;
  localparam int LAT_SPECIAL = 0;

  logic             clk;
  logic             rst_n;
  logic             issue_valid;
  logic [1:0]       issue_op;
  logic [XLEN-1:0]  issue_rs1_data;
  logic [XLEN-1:0]  issue_rs2_data;
  logic [TAG_W-1:0] issue_rd_tag;
  logic             ex_done;
  logic             busy;
  logic             cdb_req;
  logic             cdb_grant;
  logic [TAG_W-1:0] cdb_tag;
  logic [XLEN-1:0]  cdb_data;

  div_exec_unit #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_op(issue_op),
    .issue_rs1_data(issue_rs1_data), .issue_rs2_data(issue_rs2_data),
    .issue_rd_tag(issue_rd_tag), .ex_done(ex_done), .busy(busy), .cdb_req(cdb_req),
    .cdb_grant(cdb_grant), .cdb_tag(cdb_tag), .cdb_data(cdb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [5:0]  tag;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[16];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Entered and left at #1 after a posedge
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [5:0] tag, input string name);
    issue_valid    = 1'b1;
    issue_op       = op;
    issue_rs1_data = a;
    issue_rs2_data = b;
    issue_rd_tag   = tag;
    #1;
    chk({name, " ex_done"}, 32'(ex_done), 32'd1);
    @(posedge clk);
    #1;
    issue_valid = 1'b0;
  endtask

  task automatic wait_req(output int n);
    n = 0;
    while (!cdb_req && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic grant_once(input string name);
    cdb_grant = 1'b1;
    @(posedge clk);
    #1;
    cdb_grant = 1'b0;
    chk({name, " req drop"}, 32'(cdb_req), 32'd0);
  endtask

  int lat;
  int head;
  int npub;
  int req_cycles;
  logic seen;
  logic ex_s;
  logic [5:0]  bb_tag[3];
  logic [31:0] bb_a[3];
  logic [31:0] bb_exp[3];
  logic [5:0]  pub_tag[3];

  initial begin
    vecs[0]  = '{OP_DIVU, 32'd100,        32'd7,          6'd5,  32'd14,         LAT_NORMAL};
    vecs[1]  = '{OP_REMU, 32'd100,        32'd7,          6'd6,  32'd2,          LAT_NORMAL};
    vecs[2]  = '{OP_DIV,  32'hFFFF_FFEC,  32'd3,          6'd7,  32'hFFFF_FFFA,  LAT_NORMAL};
    vecs[3]  = '{OP_REM,  32'hFFFF_FFEC,  32'd3,          6'd8,  32'hFFFF_FFFE,  LAT_NORMAL};
    vecs[4]  = '{OP_REM,  32'd20,         32'hFFFF_FFFD,  6'd9,  32'd2,          LAT_NORMAL};
    vecs[5]  = '{OP_DIV,  32'd20,         32'hFFFF_FFFD,  6'd10, 32'hFFFF_FFFA,  LAT_NORMAL};
    vecs[6]  = '{OP_DIVU, 32'h0000_1234,  32'd0,          6'd11, 32'hFFFF_FFFF,  LAT_SPECIAL};
    vecs[7]  = '{OP_REMU, 32'h0000_1234,  32'd0,          6'd12, 32'h0000_1234,  LAT_SPECIAL};
    vecs[8]  = '{OP_DIV,  32'd5,          32'd0,          6'd13, 32'hFFFF_FFFF,  LAT_SPECIAL};
    vecs[9]  = '{OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  6'd14, 32'd0,          LAT_SPECIAL};
    vecs[10] = '{OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  6'd15, 32'h8000_0000,  LAT_SPECIAL};
    vecs[11] = '{OP_DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  6'd16, 32'd0,          LAT_NORMAL};
    vecs[12] = '{OP_REMU, 32'h8000_0000,  32'hFFFF_FFFF,  6'd17, 32'h8000_0000,  LAT_NORMAL};
    vecs[13] = '{OP_DIV,  32'h8000_0000,  32'd2,          6'd18, 32'hC000_0000,  LAT_NORMAL};
    vecs[14] = '{OP_DIVU, 32'hFFFF_FFFF,  32'd1,          6'd63, 32'hFFFF_FFFF,  LAT_NORMAL};
    vecs[15] = '{OP_REM,  32'hFFFF_FFF9,  32'hFFFF_FFFE,  6'd19, 32'hFFFF_FFFF,  LAT_NORMAL};

    rst_n = 1'b0; issue_valid = 1'b0; issue_op = 2'b00; issue_rs1_data = '0;
    issue_rs2_data = '0; issue_rd_tag = '0; cdb_grant = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset cdb_req", 32'(cdb_req), 32'd0);
    chk("reset cdb_tag", 32'(cdb_tag), 32'd0);
    chk("reset cdb_data", cdb_data, 32'd0);
    chk("reset ex_done", 32'(ex_done), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 16; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag, $sformatf("vec%0d", i));
      wait_req(lat);
      chk($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].lat));
      chk($sformatf("vec%0d tag", i), 32'(cdb_tag), 32'(vecs[i].tag));
      chk($sformatf("vec%0d data", i), cdb_data, vecs[i].exp);
      grant_once($sformatf("vec%0d", i));
      chk($sformatf("vec%0d idle", i), 32'(busy), 32'd0);
    end

    // Backpressure: result held in DONE while a new op waits
    issue(OP_DIVU, 32'd100, 32'd7, 6'd1, "hold first");
    wait_req(lat);
    chk("hold first latency", 32'(lat), 32'(LAT_NORMAL));
    issue_valid = 1'b1; issue_op = OP_REMU; issue_rs1_data = 32'd100;
    issue_rs2_data = 32'd7; issue_rd_tag = 6'd2;
    for (int k = 0; k < 10; k++) begin
      #1;
      chk($sformatf("hold%0d ex_done", k), 32'(ex_done), 32'd0);
      chk($sformatf("hold%0d cdb_req", k), 32'(cdb_req), 32'd1);
      chk($sformatf("hold%0d tag", k), 32'(cdb_tag), 32'd1);
      chk($sformatf("hold%0d data", k), cdb_data, 32'd14);
      @(posedge clk);
      #1;
    end
    cdb_grant = 1'b1;
    #1;
    chk("hold grant ex_done", 32'(ex_done), 32'd1);
    @(posedge clk);
    #1;
    cdb_grant = 1'b0; issue_valid = 1'b0;
    chk("hold new op busy", 32'(busy), 32'd1);
    chk("hold new op req", 32'(cdb_req), 32'd0);
    wait_req(lat);
    chk("hold second latency", 32'(lat), 32'(LAT_NORMAL));
    chk("hold second tag", 32'(cdb_tag), 32'd2);
    chk("hold second data", cdb_data, 32'd2);
    grant_once("hold second");

    // Reset while BUSY at count 15: op must vanish
    issue(OP_DIVU, 32'd1000, 32'd3, 6'd9, "midrst");
    repeat (15) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("midrst busy", 32'(busy), 32'd0);
    chk("midrst cdb_req", 32'(cdb_req), 32'd0);
    chk("midrst cdb_tag", 32'(cdb_tag), 32'd0);
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (cdb_req) seen = 1'b1;
    end
    chk("midrst never published", 32'(seen), 32'd0);

    // Back-to-back with permanent grant
    bb_tag[0] = 6'd20; bb_a[0] = 32'd50; bb_exp[0] = 32'd10;
    bb_tag[1] = 6'd21; bb_a[1] = 32'd77; bb_exp[1] = 32'd15;
    bb_tag[2] = 6'd22; bb_a[2] = 32'd9;  bb_exp[2] = 32'd1;
    head = 0; npub = 0; req_cycles = 0;
    cdb_grant = 1'b1;
    for (int c = 0; c < 200; c++) begin
      issue_valid    = (head < 3);
      issue_op       = OP_DIVU;
      issue_rs1_data = (head < 3) ? bb_a[head] : 32'd0;
      issue_rs2_data = 32'd5;
      issue_rd_tag   = (head < 3) ? bb_tag[head] : 6'd0;
      #1;
      if (cdb_req) begin
        req_cycles++;
        if (npub < 3) begin
          pub_tag[npub] = cdb_tag;
          chk($sformatf("b2b pub%0d data", npub), cdb_data, bb_exp[npub]);
          npub++;
        end
      end
      ex_s = ex_done;
      @(posedge clk);
      #1;
      if (ex_s) head++;
    end
    cdb_grant = 1'b0; issue_valid = 1'b0;
    chk("b2b publish count", 32'(npub), 32'd3);
    chk("b2b req cycles", 32'(req_cycles), 32'd3);
    for (int i = 0; i < 3; i++)
      if (i < npub) chk($sformatf("b2b tag%0d", i), 32'(pub_tag[i]), 32'(bb_tag[i]));
    chk("b2b final idle", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
